// File: rtl/scarv_soc_bram_initiator.sv
// Bridges a req/gnt + recv/ack memory bus onto one BRAM port; responses appear 1 cycle after accept.
// A stalled response is parked in a hold register and new grants are blocked until it drains.
module scarv_soc_bram_initiator #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  localparam int unsigned LW   = $clog2(DEPTH)
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          mem_req,
  output logic          mem_gnt,
  input  logic          mem_wen,
  input  logic [3:0]    mem_strb,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic          mem_recv,
  input  logic          mem_ack,
  output logic          mem_error,
  output logic [31:0]   mem_rdata,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [LW-1:0] bram_addr,
  output logic [31:0]   bram_din,
  input  logic [31:0]   bram_dout
);

  logic        hit;
  logic        accept;
  logic        r1_valid;
  logic        r1_error;
  logic        r1_wen;
  logic [31:0] r1_rdata;
  logic        h_valid;
  logic        h_error;
  logic [31:0] h_rdata;

  assign hit = (mem_addr[31:LW] == BASE[31:LW]);

  // Grant only when no response would be left stranded next cycle.
  assign mem_gnt = !rsta && !h_valid && !(r1_valid && !mem_ack);
  assign accept  = mem_req && mem_gnt;

  assign bram_en   = accept && hit;
  assign bram_we   = (bram_en && mem_wen) ? mem_strb : 4'b0000;
  assign bram_addr = mem_addr[LW-1:0];
  assign bram_din  = mem_wdata;

  assign r1_rdata = (r1_error || r1_wen) ? 32'h0 : bram_dout;

  always_comb begin
    mem_recv  = 1'b0;
    mem_error = 1'b0;
    mem_rdata = 32'h0;
    if (!rsta) begin
      if (h_valid) begin
        mem_recv  = 1'b1;
        mem_error = h_error;
        mem_rdata = h_rdata;
      end else if (r1_valid) begin
        mem_recv  = 1'b1;
        mem_error = r1_error;
        mem_rdata = r1_rdata;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r1_valid <= 1'b0;
      r1_error <= 1'b0;
      r1_wen   <= 1'b0;
      h_valid  <= 1'b0;
      h_error  <= 1'b0;
      h_rdata  <= 32'h0;
    end else begin
      r1_valid <= accept;
      if (accept) begin
        r1_error <= !hit;
        r1_wen   <= mem_wen;
      end
      // bram_dout is only trusted for one cycle, so a stalled read is copied out here.
      if (h_valid) begin
        if (mem_ack) h_valid <= 1'b0;
      end else if (r1_valid && !mem_ack) begin
        h_valid <= 1'b1;
        h_error <= r1_error;
        h_rdata <= r1_rdata;
      end
    end
  end

endmodule

// File: tb/tb_scarv_soc_bram_initiator.sv
// Directed bench for scarv_soc_bram_initiator with a BRAM port model and a response scoreboard.
module tb_scarv_soc_bram_initiator;

  localparam int LW     = 10;
  localparam int NWORDS = 256;

  logic          clka = 1'b0;
  logic          rsta;
  logic          mem_req;
  logic          mem_gnt;
  logic          mem_wen;
  logic [3:0]    mem_strb;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_recv;
  logic          mem_ack;
  logic          mem_error;
  logic [31:0]   mem_rdata;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [LW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;

  scarv_soc_bram_initiator #(.DEPTH(1024), .BASE(32'h0000_0000)) dut (
    .clka(clka), .rsta(rsta),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error), .mem_rdata(mem_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clka = ~clka;

  // BRAM model: port A driven by the DUT, port B and bulk preload driven by the bench.
  logic [31:0] bram_mem [NWORDS];
  logic [31:0] ref_mem  [NWORDS];
  logic        preload;
  logic        pb_en;
  logic [7:0]  pb_idx;
  logic [31:0] pb_data;

  always @(posedge clka) begin
    if (preload) begin
      for (int i = 0; i < NWORDS; i++) bram_mem[i] <= ref_mem[i];
    end else begin
      if (bram_en) begin
        bram_dout <= bram_mem[bram_addr[LW-1:2]];
        for (int b = 0; b < 4; b++)
          if (bram_we[b]) bram_mem[bram_addr[LW-1:2]][8*b +: 8] <= bram_din[8*b +: 8];
      end else begin
        bram_dout <= $urandom;
      end
      if (pb_en) bram_mem[pb_idx] <= pb_data;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic popped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic wen, input logic [3:0] strb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    mem_req   = req;
    mem_wen   = wen;
    mem_strb  = strb;
    mem_addr  = addr;
    mem_wdata = wdata;
  endtask

  // Sample at the falling edge: retire responses against the scoreboard, queue expectations for accepts.
  task automatic cyc();
    rsp_t r;
    logic [31:0] w;
    @(negedge clka);
    popped = 1'b0;
    check("invariant_h_r1", {31'b0, dut.h_valid && dut.r1_valid}, 32'h0);
    if (mem_recv && mem_ack) begin
      popped = 1'b1;
      if (sb.size() == 0) begin
        check("spurious_response", 32'h1, 32'h0);
      end else begin
        r = sb.pop_front();
        check("rsp_error", {31'b0, mem_error}, {31'b0, r.err});
        check("rsp_rdata", mem_rdata, r.rdata);
      end
    end
    if (rsta) begin
      sb.delete();
    end else if (mem_req && mem_gnt) begin
      if (mem_addr[31:LW] != '0) begin
        r.err = 1'b1; r.rdata = 32'h0;
      end else if (mem_wen) begin
        w = ref_mem[mem_addr[LW-1:2]];
        for (int b = 0; b < 4; b++)
          if (mem_strb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        ref_mem[mem_addr[LW-1:2]] = w;
        r.err = 1'b0; r.rdata = 32'h0;
      end else begin
        r.err = 1'b0; r.rdata = ref_mem[mem_addr[LW-1:2]];
      end
      sb.push_back(r);
    end
  endtask

  task automatic edge_();
    @(posedge clka);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      cyc();
      edge_();
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    rsta = 1'b1; mem_ack = 1'b1; pb_en = 1'b0; pb_idx = '0; pb_data = '0; preload = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = (i * 32'h0101_0101) ^ 32'h5A00_00A5;
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    ref_mem[32'h40 >> 2]  = 32'hAABB_CCDD;

    // Reset state with a request pending.
    edge_();
    preload = 1'b0;
    cyc();
    check("reset_gnt", {31'b0, mem_gnt}, 32'h0);
    check("reset_recv", {31'b0, mem_recv}, 32'h0);
    check("reset_bram_en", {31'b0, bram_en}, 32'h0);
    edge_();
    rsta = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(); edge_();

    // Read hit.
    drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    cyc();
    check("rd_gnt", {31'b0, mem_gnt}, 32'h1);
    check("rd_bram_en", {31'b0, bram_en}, 32'h1);
    check("rd_bram_addr", {22'b0, bram_addr}, 32'h100);
    edge_();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    check("rd_recv", {31'b0, mem_recv}, 32'h1);
    check("rd_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("rd_error", {31'b0, mem_error}, 32'h0);
    edge_();

    // Partial write then read-back in the next cycle.
    drive(1'b1, 1'b1, 4'b0110, 32'h40, 32'h1122_3344);
    cyc();
    check("wr_bram_we", {28'b0, bram_we}, 32'h6);
    check("wr_bram_din", bram_din, 32'h1122_3344);
    edge_();
    drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    cyc();
    check("wr_rsp_recv", {31'b0, mem_recv}, 32'h1);
    check("wr_rsp_rdata", mem_rdata, 32'h0);
    check("wr_rsp_error", {31'b0, mem_error}, 32'h0);
    check("rb_gnt", {31'b0, mem_gnt}, 32'h1);
    check("rb_bram_we", {28'b0, bram_we}, 32'h0);
    edge_();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    check("rb_rdata", mem_rdata, 32'hAA22_33DD);
    edge_();

    // Streaming: 8 back-to-back reads, one response per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0);
      cyc();
      check("stream_gnt", {31'b0, mem_gnt}, 32'h1);
      if (i > 0) check("stream_rsp_cycle", {31'b0, popped}, 32'h1);
      edge_();
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    check("stream_last_rsp", {31'b0, popped}, 32'h1);
    check("stream_sb_empty", sb.size(), 0);
    edge_();

    // Back-pressure: three cycles without ack while port B overwrites the location.
    drive(1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
    mem_ack = 1'b0;
    cyc();
    check("bp_accept", {31'b0, mem_gnt}, 32'h1);
    edge_();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("bp_recv", {31'b0, mem_recv}, 32'h1);
      check("bp_gnt", {31'b0, mem_gnt}, 32'h0);
      if (sb.size() == 0) check("bp_sb_entry", 32'h0, 32'h1);
      else check("bp_rdata", mem_rdata, sb[0].rdata);
      if (k == 0) begin
        pb_en = 1'b1; pb_idx = 8'(32'h80 >> 2); pb_data = 32'hC0FF_EE00;
        ref_mem[32'h80 >> 2] = 32'hC0FF_EE00;
      end
      edge_();
      pb_en = 1'b0;
    end
    mem_ack = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
    cyc();
    check("bp_release_recv", {31'b0, popped}, 32'h1);
    check("bp_gnt_while_hold", {31'b0, mem_gnt}, 32'h0);
    edge_();
    cyc();
    check("bp_gnt_after_drain", {31'b0, mem_gnt}, 32'h1);
    edge_();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    check("bp_new_data", mem_rdata, 32'hC0FF_EE00);
    edge_();

    // Miss outside the window.
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0400, 32'h0);
    cyc();
    check("miss_gnt", {31'b0, mem_gnt}, 32'h1);
    check("miss_bram_en", {31'b0, bram_en}, 32'h0);
    edge_();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    check("miss_recv", {31'b0, mem_recv}, 32'h1);
    check("miss_error", {31'b0, mem_error}, 32'h1);
    check("miss_rdata", mem_rdata, 32'h0);
    edge_();
    drain();

    // Reset the cycle after an accept.
    drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    cyc(); edge_();
    rsta = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    check("rst1_recv", {31'b0, mem_recv}, 32'h0);
    check("rst1_gnt", {31'b0, mem_gnt}, 32'h0);
    edge_();
    rsta = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      check("rst1_no_stale", {31'b0, mem_recv}, 32'h0);
      edge_();
    end

    // Reset while the hold register is occupied.
    drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    mem_ack = 1'b0;
    cyc(); edge_();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(); edge_();
    cyc();
    check("rst2_held", {31'b0, mem_recv}, 32'h1);
    edge_();
    rsta = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    cyc();
    check("rst2_recv", {31'b0, mem_recv}, 32'h0);
    check("rst2_gnt", {31'b0, mem_gnt}, 32'h0);
    check("rst2_bram_en", {31'b0, bram_en}, 32'h0);
    edge_();
    rsta = 1'b0;
    mem_ack = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      check("rst2_no_stale", {31'b0, mem_recv}, 32'h0);
      edge_();
    end

    // First read after reset.
    drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    cyc();
    check("post_rst_gnt", {31'b0, mem_gnt}, 32'h1);
    check("post_rst_bram_en", {31'b0, bram_en}, 32'h1);
    edge_();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    check("post_rst_recv", {31'b0, mem_recv}, 32'h1);
    check("post_rst_rdata", mem_rdata, 32'hDEAD_BEEF);
    edge_();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
